// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator initiator slice:
// FSM state encoding, default widths and a counter-width helper.
package accum_pkg;

    localparam int ACCUM_WIDTH_DEF = 16;
    localparam int ADD_WIDTH_DEF   = ACCUM_WIDTH_DEF / 2;

    // Handshake sequencer states. ST_ERR is only reachable when the
    // watchdog is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    // Bits needed to hold any value 0..max_val inclusive (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/accum_initiator_if.sv
// Bundle of the operand stream (in_valid/in_ready/in_data) and the
// four-phase accumulator link (en/add/done/accum).
//
// Stream handshake: an operand transfers on a rising clk edge where
// in_valid and in_ready are both 1; in_data must be stable while
// in_valid is high, and in_ready never depends combinationally on
// in_valid.
// Accumulator handshake: en rises with add, waits for done=1, drops,
// then waits for done=0 before the next request.
interface accum_initiator_if
    import accum_pkg::*;
#(
    parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
    parameter int ADD_WIDTH   = ACCUM_WIDTH / 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ADD_WIDTH-1:0]   in_data;
    logic                   en;
    logic [ADD_WIDTH-1:0]   add;
    logic                   done;
    logic [ACCUM_WIDTH-1:0] accum;

    // The initiator: consumes the stream, drives the accumulator.
    modport master (
        input  in_valid,
        output in_ready,
        input  in_data,
        output en,
        output add,
        input  done,
        input  accum
    );

    // The environment: operand producer plus accumulator.
    modport slave (
        output in_valid,
        input  in_ready,
        output in_data,
        input  en,
        input  add,
        output done,
        output accum
    );
endinterface

// File: rtl/accum_fifo.sv
// Small synchronous FIFO with registered occupancy count. Head data is
// visible on rdata_o whenever empty_o is low. Pushes while full and
// pops while empty are ignored.
module accum_fifo
    import accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next state; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/accum_initiator.sv
// Requester-side driver for an accumulator: buffers operands, issues
// each over the four-phase en/add/done handshake, keeps a shadow sum
// and flags any disagreement with the accumulator's accum output.
// Optional watchdog: define ACCUM_INIT_TIMEOUT_EN to trap a stalled
// handshake in ST_ERR after TIMEOUT_CYCLES cycles.
module accum_initiator
    import accum_pkg::*;
#(
    parameter int ACCUM_WIDTH    = ACCUM_WIDTH_DEF,
    parameter int ADD_WIDTH      = ACCUM_WIDTH / 2,
    parameter int DEPTH          = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    accum_initiator_if.master      bus,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   txn_count,
    output logic [ACCUM_WIDTH-1:0] expected,
    output logic                   mismatch,
    output logic                   timeout,
    output state_t                 state_dbg
);
    localparam int FCW = cnt_width(DEPTH);

    state_t                 state_q, state_d;
    logic                   en_q, en_d;
    logic [ADD_WIDTH-1:0]   add_q, add_d;
    logic [ACCUM_WIDTH-1:0] expected_q, expected_d;
    logic [CNT_WIDTH-1:0]   txn_q, txn_d;
    logic                   mismatch_q, mismatch_d;
    logic [ACCUM_WIDTH-1:0] sum;

    logic                   fifo_push, fifo_pop;
    logic                   fifo_full, fifo_empty;
    logic [ADD_WIDTH-1:0]   fifo_head;
    logic [FCW-1:0]         fifo_count;
    logic                   accept_en;

`ifdef ACCUM_INIT_TIMEOUT_EN
    localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // The FIFO is frozen once the watchdog has fired.
    assign accept_en = (state_q != ST_ERR);
    assign timeout   = timeout_q;
`else
    assign accept_en = 1'b1;
    // Without the watchdog the limit has no effect and the flag is low.
    assign timeout   = (TIMEOUT_CYCLES < 1) ? 1'b0 : 1'b0;
`endif

    // Ready comes from the registered count, so a full FIFO stays
    // not-ready even in a cycle where it is also being popped.
    assign bus.in_ready = !fifo_full && accept_en;
    assign fifo_push    = bus.in_valid && bus.in_ready;

    accum_fifo #(
        .WIDTH (ADD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (bus.in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Shadow sum including the operand in flight; wraps at ACCUM_WIDTH.
    assign sum = expected_q + ACCUM_WIDTH'(add_q);

    assign bus.en    = en_q;
    assign bus.add   = add_q;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);
    assign txn_count = txn_q;
    assign expected  = expected_q;
    assign mismatch  = mismatch_q;
    assign state_dbg = state_q;

    // Handshake sequencer: next state, request outputs, shadow update.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        add_d      = add_q;
        expected_d = expected_q;
        txn_d      = txn_q;
        mismatch_d = mismatch_q;
        fifo_pop   = 1'b0;
`ifdef ACCUM_INIT_TIMEOUT_EN
        wd_d       = wd_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // done may still be high from a handshake cut short by
                // reset; never raise en on top of it.
                if (!fifo_empty && !bus.done) begin
                    fifo_pop = 1'b1;
                    add_d    = fifo_head;
                    en_d     = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // accum is updated on the edge done rises, so it is
                // already valid here.
                if (bus.done) begin
                    en_d       = 1'b0;
                    expected_d = sum;
                    txn_d      = txn_q + CNT_WIDTH'(1);
                    if (bus.accum != sum) mismatch_d = 1'b1;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        add_d    = fifo_head;
                        en_d     = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
`ifdef ACCUM_INIT_TIMEOUT_EN
                // Trapped until reset.
                en_d    = 1'b0;
                state_d = ST_ERR;
`else
                en_d    = 1'b0;
                state_d = ST_IDLE;
`endif
            end
        endcase
`ifdef ACCUM_INIT_TIMEOUT_EN
        // Watchdog: restarts on any transition, counts while waiting on
        // the accumulator, fires after TIMEOUT_CYCLES stalled cycles.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (state_q == ST_REQ || state_q == ST_RELEASE) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_ERR;
                en_d      = 1'b0;
                timeout_d = 1'b1;
                wd_d      = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    // Sequencer, request and checker registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            add_q      <= '0;
            expected_q <= '0;
            txn_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            add_q      <= add_d;
            expected_q <= expected_d;
            txn_q      <= txn_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef ACCUM_INIT_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_accum_initiator.sv
// Directed bench for accum_initiator with a behavioural accumulator
// that answers one cycle after en, with knobs for stall, extra done
// hold and a one-transaction accum corruption.
module tb_accum_initiator;
    import accum_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    accum_initiator_if #(.ACCUM_WIDTH(AW), .ADD_WIDTH(DW)) bus ();

    logic          busy;
    logic [15:0]   txn_count;
    logic [AW-1:0] expected;
    logic          mismatch;
    logic          timeout;
    state_t        state_dbg;

    accum_initiator #(
        .ACCUM_WIDTH    (AW),
        .ADD_WIDTH      (DW),
        .DEPTH          (4),
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .busy      (busy),
        .txn_count (txn_count),
        .expected  (expected),
        .mismatch  (mismatch),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // ---------------- accumulator model ----------------
    logic          done_m = 1'b0;
    logic [AW-1:0] accum_m = '0;
    logic [AW-1:0] acc_true = '0;
    int            mtxn = 0;
    int            hold_left = 0;
    int            hold_extra = 0;
    int            corrupt_idx = 0;
    logic          stall = 1'b0;
    logic          model_clr = 1'b0;

    assign bus.done  = done_m;
    assign bus.accum = accum_m;

    always @(posedge clk) begin
        if (!done_m && bus.en && !stall) begin
            done_m    <= 1'b1;
            hold_left <= hold_extra;
            mtxn      <= mtxn + 1;
            acc_true  <= acc_true + AW'(bus.add);
            accum_m   <= acc_true + AW'(bus.add) + ((mtxn + 1 == corrupt_idx) ? AW'(1) : AW'(0));
        end else if (done_m && !bus.en) begin
            if (hold_left > 0) hold_left <= hold_left - 1;
            else               done_m    <= 1'b0;
        end
        if (model_clr) begin
            acc_true <= '0;
            accum_m  <= '0;
            mtxn     <= 0;
        end
    end

    // ---------------- handshake monitor ----------------
    logic          en_prev = 1'b0;
    logic          done_prev = 1'b0;
    logic [DW-1:0] add_prev = '0;
    int            viol = 0;
    logic [DW-1:0] got_q[$];

    always @(negedge clk) begin
        if (bus.en && !en_prev) begin
            got_q.push_back(bus.add);
            if (done_prev) viol = viol + 1;
        end
        if (bus.en && en_prev && (bus.add != add_prev)) viol = viol + 1;
        en_prev   = bus.en;
        done_prev = done_m;
        add_prev  = bus.add;
    end

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clr = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clr = 1'b0;
    endtask

    task automatic push_op(input logic [DW-1:0] d);
        int   guard;
        logic took;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            took = bus.in_ready;
            tick();
            guard++;
        end while (!took && guard < 100);
        bus.in_valid = 1'b0;
        if (!took) begin
            n_chk++;
            $display("FAIL push_accept: in_ready got 0 want 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while ((busy || bus.en || done_m) && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) begin
            n_chk++;
            $display("FAIL %s_idle: busy got 1 want 0 within 400 cycles", tag);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        do_reset();
        n_chk++; if (bus.en !== 1'b0) $display("FAIL reset_en: got %0b want 0", bus.en); else n_pass++;
        n_chk++; if (bus.add !== 8'h00) $display("FAIL reset_add: got %h want 00", bus.add); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_chk++; if (txn_count !== 16'd0) $display("FAIL reset_txn: got %0d want 0", txn_count); else n_pass++;
        n_chk++; if (expected !== 16'h0000) $display("FAIL reset_expected: got %h want 0000", expected); else n_pass++;
        n_chk++; if (mismatch !== 1'b0) $display("FAIL reset_mismatch: got %0b want 0", mismatch); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", timeout); else n_pass++;
        n_chk++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    endtask

    task automatic test_single();
        int v0;
        do_reset();
        v0 = viol;
        push_op(8'h05);
        n_chk++; if (bus.en !== 1'b0) $display("FAIL single_no_bypass: en got %0b want 0", bus.en); else n_pass++;
        tick();
        n_chk++; if (bus.en !== 1'b1) $display("FAIL single_en: got %0b want 1", bus.en); else n_pass++;
        n_chk++; if (bus.add !== 8'h05) $display("FAIL single_add: got %h want 05", bus.add); else n_pass++;
        wait_idle("single");
        n_chk++; if (expected !== 16'h0005) $display("FAIL single_expected: got %h want 0005", expected); else n_pass++;
        n_chk++; if (txn_count !== 16'd1) $display("FAIL single_txn: got %0d want 1", txn_count); else n_pass++;
        n_chk++; if (mismatch !== 1'b0) $display("FAIL single_mismatch: got %0b want 0", mismatch); else n_pass++;
        n_chk++; if (viol !== v0) $display("FAIL single_handshake: violations got %0d want %0d", viol, v0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = got_q.size();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        stall = 1'b1;
        for (int i = 1; i <= 5; i++) push_op(DW'(i));
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0b want 0", bus.in_ready); else n_pass++;
        // Offers while full must be dropped.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_still_full: got %0b want 0", bus.in_ready); else n_pass++;
        stall = 1'b0;
        wait_idle("b2b");
        n_chk++; if (got_q.size() - base !== 5) $display("FAIL b2b_count_delivered: got %0d want 5", got_q.size() - base); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (base + i < got_q.size()) begin
                n_chk++;
                if (got_q[base + i] !== exp_q[i]) $display("FAIL b2b_order[%0d]: got %h want %h", i, got_q[base + i], exp_q[i]);
                else n_pass++;
            end
        end
        n_chk++; if (expected !== 16'h000F) $display("FAIL b2b_expected: got %h want 000F", expected); else n_pass++;
        n_chk++; if (txn_count !== 16'd5) $display("FAIL b2b_txn: got %0d want 5", txn_count); else n_pass++;
        n_chk++; if (mismatch !== 1'b0) $display("FAIL b2b_mismatch: got %0b want 0", mismatch); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) push_op(8'hFF);
        wait_idle("wrap_pre");
        n_chk++; if (expected !== 16'hFF00) $display("FAIL wrap_preload: got %h want FF00", expected); else n_pass++;
        n_chk++; if (txn_count !== 16'd256) $display("FAIL wrap_txn: got %0d want 256", txn_count); else n_pass++;
        push_op(8'hFF);
        wait_idle("wrap_ff");
        n_chk++; if (expected !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want FFFF", expected); else n_pass++;
        push_op(8'h01);
        wait_idle("wrap_01");
        n_chk++; if (expected !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", expected); else n_pass++;
        n_chk++; if (mismatch !== 1'b0) $display("FAIL wrap_mismatch: got %0b want 0", mismatch); else n_pass++;
    endtask

    task automatic test_mismatch();
        do_reset();
        corrupt_idx = 3;
        push_op(8'h10); wait_idle("mm1");
        push_op(8'h20); wait_idle("mm2");
        n_chk++; if (mismatch !== 1'b0) $display("FAIL mm_before: got %0b want 0", mismatch); else n_pass++;
        push_op(8'h30); wait_idle("mm3");
        n_chk++; if (mismatch !== 1'b1) $display("FAIL mm_raised: got %0b want 1", mismatch); else n_pass++;
        push_op(8'h40); wait_idle("mm4");
        n_chk++; if (mismatch !== 1'b1) $display("FAIL mm_sticky: got %0b want 1", mismatch); else n_pass++;
        n_chk++; if (expected !== 16'h00A0) $display("FAIL mm_expected: got %h want 00A0", expected); else n_pass++;
        corrupt_idx = 0;
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        hold_extra = 3;
        push_op(8'h07);
        tick();
        n_chk++; if (bus.en !== 1'b1) $display("FAIL rmid_en_before: got %0b want 1", bus.en); else n_pass++;
        reset = 1'b1;
        model_clr = 1'b1;
        tick();
        reset = 1'b0;
        model_clr = 1'b0;
        hold_extra = 0;
        n_chk++; if (bus.en !== 1'b0) $display("FAIL rmid_en_drop: got %0b want 0", bus.en); else n_pass++;
        n_chk++; if (done_m !== 1'b1) $display("FAIL rmid_done_held: got %0b want 1", done_m); else n_pass++;
        n_chk++; if (expected !== 16'h0000) $display("FAIL rmid_expected_clr: got %h want 0000", expected); else n_pass++;
        push_op(8'h09);
        guard = 0;
        while (done_m && guard < 10) begin
            n_chk++; if (bus.en !== 1'b0) $display("FAIL rmid_en_while_done: got %0b want 0", bus.en); else n_pass++;
            tick();
            guard++;
        end
        tick();
        n_chk++; if (bus.en !== 1'b1) $display("FAIL rmid_en_after: got %0b want 1", bus.en); else n_pass++;
        n_chk++; if (bus.add !== 8'h09) $display("FAIL rmid_add: got %h want 09", bus.add); else n_pass++;
        wait_idle("rmid");
        n_chk++; if (expected !== 16'h0009) $display("FAIL rmid_expected: got %h want 0009", expected); else n_pass++;
        n_chk++; if (mismatch !== 1'b0) $display("FAIL rmid_mismatch: got %0b want 0", mismatch); else n_pass++;
        n_chk++; if (txn_count !== 16'd1) $display("FAIL rmid_txn: got %0d want 1", txn_count); else n_pass++;
    endtask

`ifdef ACCUM_INIT_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        stall = 1'b1;
        push_op(8'h11);
        for (int i = 0; i < 16; i++) tick();
        n_chk++; if (timeout !== 1'b0) $display("FAIL to_early: got %0b want 0", timeout); else n_pass++;
        n_chk++; if (bus.en !== 1'b1) $display("FAIL to_en_early: got %0b want 1", bus.en); else n_pass++;
        tick();
        n_chk++; if (timeout !== 1'b1) $display("FAIL to_fire: got %0b want 1", timeout); else n_pass++;
        n_chk++; if (bus.en !== 1'b0) $display("FAIL to_en: got %0b want 0", bus.en); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL to_ready: got %0b want 0", bus.in_ready); else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (timeout !== 1'b1) $display("FAIL to_hold: got %0b want 1", timeout); else n_pass++;
        n_chk++; if (state_dbg !== ST_ERR) $display("FAIL to_state: got %0d want 3", state_dbg); else n_pass++;
        stall = 1'b0;
        do_reset();
        n_chk++; if (timeout !== 1'b0) $display("FAIL to_cleared: got %0b want 0", timeout); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_mismatch();
        test_reset_mid();
`ifdef ACCUM_INIT_TIMEOUT_EN
        test_timeout();
`endif
        n_chk++; if (viol !== 0) $display("FAIL handshake_rules: violations got %0d want 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/accum_initiator.md
Name: accum_initiator

Overview:
- Requester-side counterpart to the accumulator block. Accepts operands on a valid/ready stream and buffers them in a small FIFO.
- Drives each operand to an accumulator over the four-phase en/add/done handshake.
- Keeps a shadow (expected) sum and flags any mismatch against the accumulator's accum output.
- Used as the stimulus/check engine in front of accumulator models in the SST test harnesses.

Parameters:
- ACCUM_WIDTH, 16, width of accum and of the shadow sum.
- ADD_WIDTH, ACCUM_WIDTH/2, operand width.
- DEPTH, 4, operand FIFO depth; power of two, >=2.
- CNT_WIDTH, 16, completed-transaction counter width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with ACCUM_INIT_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  FIFO can accept; equals !full (also low in ERR).
- in_data  in  ADD_WIDTH  operand.
- en  out  1  request to accumulator; registered.
- add  out  ADD_WIDTH  operand to accumulator; registered, stable while en=1.
- done  in  1  accumulator completion.
- accum  in  ACCUM_WIDTH  accumulator's current value.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- txn_count  out  CNT_WIDTH  completed handshakes.
- expected  out  ACCUM_WIDTH  shadow sum.
- mismatch  out  1  sticky compare failure.
- timeout  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

Behaviour:
- Reset (sync, high), effective at the next edge:
  - en=0, add=0, FIFO emptied, in_ready=1, busy=0, txn_count=0, expected=0, mismatch=0, timeout=0, state=IDLE.
- Reset mid-handshake:
  - en drops at that edge. The accumulator may still hold done=1.
  - IDLE issues nothing until done=0 is sampled.
- Push: in_valid&&in_ready at an edge writes in_data. No FIFO bypass. Push and pop in the same cycle are allowed.
- FSM states IDLE, REQ, RELEASE, ERR:
  - IDLE:
    - If FIFO non-empty and done==0: pop, add<=head, en<=1, go REQ.
    - An operand pushed at edge N produces en=1 after edge N+1.
  - REQ:
    - Hold en=1 and add until done==1 is sampled.
    - At that edge: en<=0, expected<=expected+{0,add}, txn_count<=txn_count+1.
    - Compare accum against expected+{0,add}; inequality sets mismatch.
    - Go RELEASE.
    - The accumulator updates accum on the same edge it raises done, so accum is valid when done is seen high.
  - RELEASE:
    - Hold en=0 until done==0 is sampled.
    - At that edge: if FIFO non-empty, pop and go REQ with en<=1; otherwise go IDLE.
  - ERR: only with the watchdog; see Optional Feature.
- Handshake rules:
  - en never rises while done==1.
  - add changes only on an en 0->1 edge.
  - One operand per four-phase cycle.
- Arithmetic:
  - Operand zero-extended to ACCUM_WIDTH.
  - expected wraps modulo 2^ACCUM_WIDTH.
  - txn_count wraps modulo 2^CNT_WIDTH.
- Boundaries:
  - Full: in_ready=0; push ignored.
  - Empty in RELEASE: go IDLE.
  - Pointers wrap at DEPTH.
  - Full with pop in a cycle: in_ready stays 0 that cycle (ready derived from registered count).
  - mismatch stays set until reset.

Optional Feature:
- Macro: ACCUM_INIT_TIMEOUT_EN.
- Defined:
  - Counter clears on every FSM transition and increments while in REQ or RELEASE.
  - Reaching TIMEOUT_CYCLES goes to ERR.
  - ERR: en<=0, timeout<=1, in_ready=0, FIFO frozen.
  - Exit only by reset.
- Undefined:
  - No counter and no ERR state; the FSM waits indefinitely.
  - timeout tied 0; port list unchanged.

Decomposition:
- accum_pkg holds:
  - state enum (IDLE, REQ, RELEASE, ERR)
  - default width constants (ACCUM_WIDTH=16, ADD_WIDTH=8)
  - counter width helper function
- One sub-module: accum_fifo.
  - Parameterized sync FIFO (WIDTH, DEPTH), sync active-high reset.
  - Provides push/pop/full/empty/count.
- FSM, shadow sum and checker stay in accum_initiator.

Test Plan:
- Reset, then push 0x05 with a compliant accumulator model (done 1 cycle after en) -> en=1 with add=0x05 one cycle after push; done seen; expected=0x0005; txn_count=1; mismatch=0; en never high while done=1.
- Back-to-back push 0x01,0x02,0x03,0x04,0x05 with DEPTH=4 -> in_ready=0 after four queued; all five delivered in order; expected=0x000F; txn_count=5.
- ACCUM_WIDTH=16, preload via 0xFF pushes to expected=0xFF00, then push 0xFF and 0x01 -> expected=0xFFFF then 0x0000 (wrap); no mismatch.
- Model corrupts accum by +1 on the third transaction -> mismatch rises at that done edge and stays high through later transactions.
- Assert reset while en=1 and the model holds done=1 for 3 more cycles; push immediately after reset -> en stays 0 until done=0 is sampled, then asserts; expected restarts from 0.
- ACCUM_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never raises done -> after 16 cycles in REQ: timeout=1, en=0, in_ready=0, held until reset.
